// File: rtl/dmg_oam_dma_if.sv
// Signal bundle between the OAM DMA controller and its surroundings:
// the CPU register port (FF46), the external bus arbiter and the PPU OAM write port.
//   master : the DMA controller side (drives read requests and OAM writes)
//   slave  : the environment side (CPU, arbiter/memory, OAM)
interface dmg_oam_dma_if;
  logic        reg_wr;     // CPU write strobe to FF46
  logic [7:0]  reg_wdata;  // source page high byte
  logic [7:0]  reg_rdata;  // raw last-written source byte
  logic        bus_rd;     // DMA read request
  logic [15:0] bus_addr;   // DMA read address
  logic        bus_gnt;    // arbiter grant
  logic [7:0]  bus_rdata;  // read data, valid in granted cycle
  logic        oam_we;     // OAM write strobe
  logic [7:0]  oam_addr;   // OAM byte index
  logic [7:0]  oam_wdata;  // OAM write data
  logic        dma_busy;   // transfer in progress, CPU bus blocked
  logic        dma_done;   // one-clock completion pulse

  modport master (
    input  reg_wr, reg_wdata, bus_gnt, bus_rdata,
    output reg_rdata, bus_rd, bus_addr, oam_we, oam_addr, oam_wdata,
           dma_busy, dma_done
  );

  modport slave (
    output reg_wr, reg_wdata, bus_gnt, bus_rdata,
    input  reg_rdata, bus_rd, bus_addr, oam_we, oam_addr, oam_wdata,
           dma_busy, dma_done
  );
endinterface

// File: rtl/dmg_oam_dma.sv
// OAM DMA controller. A write to FF46 selects a source page; the block then
// copies XFER_LEN bytes from {page,00h..} into OAM, one byte every two clocks
// (READ on the external bus, then WRITE into OAM), waiting on the arbiter grant.
// Ports:
//   clk   : system clock, all state on rising edge
//   nres  : asynchronous active-low reset
//   bus   : dmg_oam_dma_if.master (register port, bus read port, OAM write port,
//           busy/done status)
module dmg_oam_dma #(
  parameter int unsigned XFER_LEN    = 160,
  parameter int unsigned START_DELAY = 2
) (
  input  logic            clk,
  input  logic            nres,
  dmg_oam_dma_if.master   bus
);

  typedef enum logic [1:0] {IDLE, DELAY, READ, WRITE} state_t;

  localparam int unsigned   DW    = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [DW-1:0] DLOAD = DW'(START_DELAY - 1);
  localparam logic [7:0]    LAST  = 8'(XFER_LEN - 1);

  state_t        state_q, state_d;
  logic [7:0]    idx_q, idx_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [7:0]    src_q, src_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;

  logic [7:0]    src_eff;
  logic          bus_rd, oam_we;
  logic [15:0]   bus_addr;
  logic [7:0]    oam_addr, oam_wdata;

  // Echo RAM pages E0..FF alias onto WRAM C0..DF.
  assign src_eff = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dcnt_d    = dcnt_q;
    src_d     = src_q;
    data_d    = data_q;
    done_d    = 1'b0;
    bus_rd    = 1'b0;
    bus_addr  = '0;
    oam_we    = 1'b0;
    oam_addr  = '0;
    oam_wdata = '0;

    unique case (state_q)
      IDLE: ;
      DELAY: begin
        if (dcnt_q == '0) state_d = READ;
        else              dcnt_d  = dcnt_q - 1'b1;
      end
      READ: begin
        bus_rd   = 1'b1;
        bus_addr = {src_eff, idx_q};
        if (bus.bus_gnt) begin
          data_d  = bus.bus_rdata;
          state_d = WRITE;
        end
      end
      WRITE: begin
        oam_we    = 1'b1;
        oam_addr  = idx_q;
        oam_wdata = data_q;
        if (idx_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase

    // A register write overrides every transition: the strobes of the current
    // cycle still go out, but a granted read is dropped and no done is raised.
    if (bus.reg_wr) begin
      state_d = DELAY;
      src_d   = bus.reg_wdata;
      idx_d   = '0;
      dcnt_d  = DLOAD;
      data_d  = data_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dcnt_q  <= '0;
      src_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dcnt_q  <= dcnt_d;
      src_q   <= src_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign bus.reg_rdata = src_q;
  assign bus.bus_rd    = bus_rd;
  assign bus.bus_addr  = bus_addr;
  assign bus.oam_we    = oam_we;
  assign bus.oam_addr  = oam_addr;
  assign bus.oam_wdata = oam_wdata;
  assign bus.dma_busy  = (state_q != IDLE);
  assign bus.dma_done  = done_q;

endmodule

// File: tb/tb_dmg_oam_dma.sv
// Bench for dmg_oam_dma: a negedge monitor holds expected bus reads and OAM
// writes (with their exact cycle numbers) queued when a register write is seen.
module tb_dmg_oam_dma;
  localparam int LEN = 160;
  localparam int SD  = 2;

  logic clk = 1'b0;
  logic nres = 1'b0;
  dmg_oam_dma_if bif ();

  dmg_oam_dma #(.XFER_LEN(LEN), .START_DELAY(SD)) dut (
    .clk  (clk),
    .nres (nres),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  // Memory model: byte = low address XOR page, so page mistakes show in data.
  assign bif.bus_rdata = bif.bus_addr[7:0] ^ bif.bus_addr[15:8];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] rd_q[$];
  logic [15:0] wr_q[$];   // {oam_addr, data}
  int  txn_k = 0;
  int  stall = 0;
  bit  done_pending = 1'b0;
  int  done_cnt = 0;
  int  wr_cnt = 0;
  int  busy_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] eff(input logic [7:0] s);
    return (s >= 8'hE0) ? s - 8'h20 : s;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (nres) begin
      check("busy", bif.dma_busy, wr_q.size() != 0);
      if (bif.dma_busy) busy_cnt++;
      if (rd_q.size() == 0) check("rd_idle", bif.bus_rd, 0);
      else if (bif.bus_rd) begin
        check("rd_addr", bif.bus_addr, rd_q[0]);
        if (bif.bus_gnt) begin
          check("rd_cyc", cyc, txn_k + SD + 2 * int'(rd_q[0][7:0]) + stall);
          void'(rd_q.pop_front());
        end else stall++;
      end
      if (wr_q.size() == 0) check("we_idle", bif.oam_we, 0);
      else if (bif.oam_we) begin
        check("oam", {bif.oam_addr, bif.oam_wdata}, wr_q[0]);
        check("we_cyc", cyc, txn_k + SD + 1 + 2 * int'(wr_q[0][15:8]) + stall);
        void'(wr_q.pop_front());
        wr_cnt++;
      end
      if (done_pending && cyc == txn_k + SD + 2 * LEN + stall) begin
        check("done", bif.dma_done, 1);
        done_pending = 1'b0;
      end else check("no_done", bif.dma_done, 0);
      if (bif.dma_done) done_cnt++;
      if (bif.reg_wr) begin
        rd_q.delete();
        wr_q.delete();
        for (int i = 0; i < LEN; i++) begin
          rd_q.push_back({eff(bif.reg_wdata), 8'(i)});
          wr_q.push_back({8'(i), eff(bif.reg_wdata) ^ 8'(i)});
        end
        txn_k = cyc + 1;
        stall = 0;
        done_pending = 1'b1;
      end
    end
  end

  task automatic start(input logic [7:0] s);
    @(posedge clk); #1;
    bif.reg_wr = 1'b1;
    bif.reg_wdata = s;
    @(posedge clk); #1;
    bif.reg_wr = 1'b0;
    check("rdata", bif.reg_rdata, s);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk); #1;
      ok = (wr_q.size() == 0) && !done_pending;
    end
    check("idle_timeout", ok, 1);
  endtask

  // Advance to the cycle where bus_rd/oam_we targets byte b (sampled #1 after edge).
  task automatic wait_byte(input bit we, input logic [7:0] b);
    bit ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk); #1;
      ok = we ? (bif.oam_we && bif.oam_addr == b) : (bif.bus_rd && bif.bus_addr[7:0] == b);
    end
    check("byte_timeout", ok, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd"},   bif.bus_rd, 0);
    check({tag, "_addr"}, bif.bus_addr, 0);
    check({tag, "_we"},   bif.oam_we, 0);
    check({tag, "_oa"},   bif.oam_addr, 0);
    check({tag, "_od"},   bif.oam_wdata, 0);
    check({tag, "_busy"}, bif.dma_busy, 0);
    check({tag, "_done"}, bif.dma_done, 0);
  endtask

  initial begin
    int d0, w0, b0;
    bit ok;
    bif.reg_wr = 1'b0;
    bif.reg_wdata = 8'h00;
    bif.bus_gnt = 1'b1;
    #12;
    check_zero("reset");
    check("reset_rdata", bif.reg_rdata, 8'h00);
    nres = 1'b1;

    // 1: plain transfer, busy length and write count
    d0 = done_cnt; w0 = wr_cnt; b0 = busy_cnt;
    start(8'hC1);
    wait_idle();
    check("t1_writes", wr_cnt - w0, LEN);
    check("t1_busy", busy_cnt - b0, 2 * LEN + SD);
    check("t1_dones", done_cnt - d0, 1);

    // 2: echo remap and boundary page
    start(8'hE3); wait_idle();
    check("t2_rdata", bif.reg_rdata, 8'hE3);
    start(8'hDF); wait_idle();
    start(8'hFF); wait_idle();

    // 3: five-clock grant stall on byte 10
    start(8'hC4);
    wait_byte(1'b0, 8'd10);
    bif.bus_gnt = 1'b0;
    repeat (5) @(posedge clk);
    #1 bif.bus_gnt = 1'b1;
    wait_idle();
    check("t3_stall", stall, 5);

    // 4: restart during WRITE of byte 50
    d0 = done_cnt;
    start(8'hC0);
    wait_byte(1'b1, 8'd50);
    bif.reg_wr = 1'b1;
    bif.reg_wdata = 8'hD0;
    @(posedge clk); #1;
    bif.reg_wr = 1'b0;
    wait_idle();
    check("t4_dones", done_cnt - d0, 1);

    // 5: reset mid-transfer, then clean run
    d0 = done_cnt;
    start(8'hC1);
    wait_byte(1'b0, 8'd80);
    #2 nres = 1'b0;
    rd_q.delete(); wr_q.delete(); done_pending = 1'b0;
    #1 check_zero("midrst");
    repeat (3) @(posedge clk);
    #1 nres = 1'b1;
    check("t5_nodone", done_cnt - d0, 0);
    start(8'h80); wait_idle();
    check("t5_dones", done_cnt - d0, 1);

    // 6: write in the done cycle, then a few random pages
    start(8'hC2);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk); #1;
      ok = bif.dma_done;
    end
    check("t6_done_seen", ok, 1);
    bif.reg_wr = 1'b1;
    bif.reg_wdata = 8'hE7;
    @(posedge clk); #1;
    bif.reg_wr = 1'b0;
    check("t6_busy", bif.dma_busy, 1);
    wait_idle();
    for (int r = 0; r < 2; r++) begin
      start(8'($urandom_range(8'hC0, 8'hFF)));
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
